// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared defaults and saturating increment for the UART receive buffer
package uart_rx_pkg;

    localparam int UART_DATA_W    = 8;
    localparam int UART_ERR_CNT_W = 8;

    // Holds at all-ones instead of wrapping back to zero.
    function automatic logic [UART_ERR_CNT_W-1:0] sat_inc(input logic [UART_ERR_CNT_W-1:0] cnt);
        logic [UART_ERR_CNT_W-1:0] one;
        one = {{(UART_ERR_CNT_W-1){1'b0}}, 1'b1};
        return (&cnt) ? cnt : cnt + one;
    endfunction

endpackage

// File: rtl/uart_pulse_det.sv
// rtl/uart_pulse_det.sv - single-bit rising-edge detector
module uart_pulse_det (
    input  logic CLK,
    input  logic RST,
    input  logic din,
    output logic pulse
);

    logic din_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign pulse = din & ~din_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive frame FIFO with error counters and overflow status
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_W,
    parameter int DEPTH      = 8,
    parameter int ERR_CNT_W  = UART_ERR_CNT_W
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [DATA_WIDTH-1:0]         P_DATA,
    input  logic                          data_valid,
    input  logic                          Parity_Error,
    input  logic                          Stop_Error,
    input  logic                          flush,
    input  logic                          rd_ready,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          rd_valid,
    output logic                          full,
    output logic [$clog2(DEPTH):0]        fifo_count,
    output logic                          overflow,
    input  logic                          clr_status,
    output logic [ERR_CNT_W-1:0]          par_err_cnt,
    output logic [ERR_CNT_W-1:0]          stp_err_cnt
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    logic                  wr_ev;
    logic                  par_ev;
    logic                  stp_ev;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  empty;
    logic                  full_int;
    logic                  pop;
    logic                  push;

    uart_pulse_det u_dv_det  (.CLK(CLK), .RST(RST), .din(data_valid),   .pulse(wr_ev));
    uart_pulse_det u_par_det (.CLK(CLK), .RST(RST), .din(Parity_Error), .pulse(par_ev));
    uart_pulse_det u_stp_det (.CLK(CLK), .RST(RST), .din(Stop_Error),   .pulse(stp_ev));

    assign empty    = (wr_ptr == rd_ptr);
    assign full_int = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                      (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
    assign pop      = ~empty & rd_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a write alongside it.
    assign push     = wr_ev & (~full_int | pop);

    assign rd_valid   = ~empty;
    assign full       = full_int;
    assign fifo_count = wr_ptr - rd_ptr;
    assign rd_data    = mem[rd_ptr[ADDR_WIDTH-1:0]];

    always_ff @(posedge CLK) begin
        if (push && !flush) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= P_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // A fresh event in the same cycle as clr_status takes priority over the clear.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            overflow    <= 1'b0;
            par_err_cnt <= '0;
            stp_err_cnt <= '0;
        end else begin
            if (wr_ev && full_int && !pop && !flush) begin
                overflow <= 1'b1;
            end else if (clr_status) begin
                overflow <= 1'b0;
            end

            if (par_ev) begin
                par_err_cnt <= clr_status ? CNT_ONE : sat_inc(par_err_cnt);
            end else if (clr_status) begin
                par_err_cnt <= '0;
            end

            if (stp_ev) begin
                stp_err_cnt <= clr_status ? CNT_ONE : sat_inc(stp_err_cnt);
            end else if (clr_status) begin
                stp_err_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for the receive frame FIFO
module tb_uart_rx_fifo;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       Parity_Error;
    logic       Stop_Error;
    logic       flush;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       clr_status;
    logic [7:0] par_err_cnt;
    logic [7:0] stp_err_cnt;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .data_valid(data_valid),
        .Parity_Error(Parity_Error), .Stop_Error(Stop_Error), .flush(flush),
        .rd_ready(rd_ready), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
        .fifo_count(fifo_count), .overflow(overflow), .clr_status(clr_status),
        .par_err_cnt(par_err_cnt), .stp_err_cnt(stp_err_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted read is matched against the head of the expected queue.
    initial begin
        forever begin
            @(negedge CLK);
            if (RST && rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_pop: got 0x%0h expected none", rd_data);
                end else begin
                    check("pop_data", {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input int hold, input bit stored);
        P_DATA = d;
        data_valid = 1'b1;
        if (stored) exp_q.push_back(d);
        repeat (hold) tick();
        data_valid = 1'b0;
        tick();
    endtask

    task automatic drain(input int n);
        rd_ready = 1'b1;
        repeat (n) tick();
        rd_ready = 1'b0;
    endtask

    initial begin
        RST = 1'b0; P_DATA = '0; data_valid = 1'b0; Parity_Error = 1'b0;
        Stop_Error = 1'b0; flush = 1'b0; rd_ready = 1'b0; clr_status = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_rd_valid", {31'h0, rd_valid}, 32'd0);
        check("reset_count", {28'h0, fifo_count}, 32'd0);
        RST = 1'b1;
        tick();

        // 1: held data_valid writes once per frame
        send(8'hA5, 3, 1'b1);
        send(8'h3C, 3, 1'b1);
        check("t1_count", {28'h0, fifo_count}, 32'd2);
        drain(2);
        check("t1_empty", {31'h0, rd_valid}, 32'd0);

        // 2: overflow drops the ninth frame
        for (int i = 0; i < 8; i++) send(i[7:0], 1, 1'b1);
        send(8'hFF, 1, 1'b0);
        check("t2_full", {31'h0, full}, 32'd1);
        check("t2_overflow", {31'h0, overflow}, 32'd1);
        check("t2_count", {28'h0, fifo_count}, 32'd8);
        drain(8);
        check("t2_empty", {28'h0, fifo_count}, 32'd0);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        check("t2_clr_overflow", {31'h0, overflow}, 32'd0);

        // 3: write into a full FIFO alongside a pop
        for (int i = 0; i < 8; i++) send(8'h10 + i[7:0], 1, 1'b1);
        P_DATA = 8'h55;
        data_valid = 1'b1;
        rd_ready = 1'b1;
        exp_q.push_back(8'h55);
        tick();
        data_valid = 1'b0;
        rd_ready = 1'b0;
        tick();
        check("t3_overflow", {31'h0, overflow}, 32'd0);
        check("t3_count", {28'h0, fifo_count}, 32'd8);
        drain(8);
        check("t3_empty", {31'h0, rd_valid}, 32'd0);

        // 4: error counter saturation and clear/event collision
        for (int i = 0; i < 300; i++) begin
            Parity_Error = 1'b1; tick();
            Parity_Error = 1'b0; tick();
        end
        check("t4_par_sat", {24'h0, par_err_cnt}, 32'd255);
        check("t4_stp_zero", {24'h0, stp_err_cnt}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            Stop_Error = 1'b1; tick();
            Stop_Error = 1'b0; tick();
        end
        check("t4_stp_two", {24'h0, stp_err_cnt}, 32'd2);
        Stop_Error = 1'b1;
        clr_status = 1'b1;
        tick();
        Stop_Error = 1'b0;
        clr_status = 1'b0;
        tick();
        check("t4_stp_clr_event", {24'h0, stp_err_cnt}, 32'd1);
        check("t4_par_cleared", {24'h0, par_err_cnt}, 32'd0);

        // 5: flush beats a same-cycle write and pop
        send(8'h21, 1, 1'b1);
        send(8'h22, 1, 1'b1);
        send(8'h23, 1, 1'b1);
        P_DATA = 8'h99;
        data_valid = 1'b1;
        rd_ready = 1'b1;
        flush = 1'b1;
        tick();
        data_valid = 1'b0;
        rd_ready = 1'b0;
        flush = 1'b0;
        exp_q.delete();
        check("t5_count", {28'h0, fifo_count}, 32'd0);
        check("t5_rd_valid", {31'h0, rd_valid}, 32'd0);
        check("t5_overflow", {31'h0, overflow}, 32'd0);
        tick();

        // 6: asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) send(8'h40 + i[7:0], 1, 1'b1);
        @(posedge CLK);
        #3 RST = 1'b0;
        #1;
        exp_q.delete();
        check("t6_rd_valid", {31'h0, rd_valid}, 32'd0);
        check("t6_count", {28'h0, fifo_count}, 32'd0);
        check("t6_full", {31'h0, full}, 32'd0);
        check("t6_overflow", {31'h0, overflow}, 32'd0);
        check("t6_stp_cnt", {24'h0, stp_err_cnt}, 32'd0);
        tick();
        RST = 1'b1;
        tick();
        send(8'h81, 1, 1'b1);
        check("t6_count_one", {28'h0, fifo_count}, 32'd1);
        drain(1);
        check("t6_empty", {31'h0, rd_valid}, 32'd0);

        tick();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
